// File: rtl/nios2_system_link_pkg.sv
// ============================================================================
// Module      : nios2_system_link_pkg
// Description : Shared definitions for the inter-board link controller:
//               register map, STATUS/CONTROL bit positions, TX FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package nios2_system_link_pkg;

  // Avalon register map (word addresses)
  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_CTRL   = 2'd2;
  localparam logic [1:0] ADDR_ERRCLR = 2'd3;

  // STATUS register bit positions
  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_TMO     = 3;
  localparam int STAT_OVF     = 4;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_MSB = 14;

  // CONTROL register bit positions
  localparam int CTRL_EN     = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  // Transmit handshake states
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SETUP   = 2'd1,
    ST_STROBE  = 2'd2,
    ST_RELEASE = 2'd3
  } tx_state_t;

endpackage

`default_nettype wire

// File: rtl/nios2_system_link_tx_fifo.sv
// ============================================================================
// Module      : nios2_system_link_tx_fifo
// Description : Synchronous DEPTH x 8 FIFO with push/pop/flush, head-of-queue
//               output, occupancy count and full/empty flags.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios2_system_link_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_push,
  input  logic [7:0]                 i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [7:0]                 o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // accepted when it coincides with a pop.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_head  = r_mem[r_rd];

  // Storage array: written on accepted push, no reset needed
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr] <= i_data;
    end
  end

  // Pointers and occupancy; flush overrides any push/pop in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + 1'b1;
      if (w_do_pop)  r_rd <= r_rd + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/nios2_system_link_tx_ctrl.sv
// ============================================================================
// Module      : nios2_system_link_tx_ctrl
// Description : Avalon-MM slave that queues bytes and sends them over the
//               8-bit inter-board link with a 4-phase strobe/ack handshake,
//               per-phase timeout and level interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module nios2_system_link_tx_ctrl
  import nios2_system_link_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int SETUP_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq,
  output logic [7:0]  out_port,
  output logic        strobe_out,
  input  logic        ack_in
);

  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  // One counter serves both SETUP (<=15) and the ack-phase timeouts
  localparam int CNT_W  = ($clog2(TIMEOUT_CYCLES) > 4) ? $clog2(TIMEOUT_CYCLES) + 1 : 5;
  localparam int STAT_CNT_W = STAT_CNT_MSB - STAT_CNT_LSB + 1;

  tx_state_t     r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]    r_last;
  logic          r_ack_m;
  logic          r_ack_s;
  logic          r_en;
  logic          r_irq_en;
  logic          r_tmo;
  logic          r_ovf;

  logic          w_wr;
  logic          w_wr_data;
  logic          w_wr_ctrl;
  logic          w_wr_errclr;
  logic          w_flush;
  logic          w_pop;
  logic          w_ovf_set;
  logic          w_tmo_set;
  logic          w_cnt_tmo;
  logic          w_busy;
  logic [7:0]    w_head;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;
  logic [STAT_CNT_W-1:0] w_count_ext;
  logic          w_unused_wdata;

  assign w_wr        = chipselect && !write_n;
  assign w_wr_data   = w_wr && (address == ADDR_DATA);
  assign w_wr_ctrl   = w_wr && (address == ADDR_CTRL);
  assign w_wr_errclr = w_wr && (address == ADDR_ERRCLR);
  assign w_flush     = w_wr_ctrl && writedata[CTRL_FLUSH];
  assign w_unused_wdata = ^writedata[31:8];

  assign w_busy    = (r_state != ST_IDLE);
  assign w_cnt_tmo = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  // Handshake completes once the synchronised ack has returned low
  assign w_pop     = (r_state == ST_RELEASE) && !r_ack_s && !w_flush;
  assign w_tmo_set = !w_flush && w_cnt_tmo &&
                     (((r_state == ST_STROBE) && !r_ack_s) ||
                      ((r_state == ST_RELEASE) && r_ack_s));
  assign w_ovf_set = w_wr_data && w_full && !w_pop;

  assign irq = r_irq_en && (r_tmo || (w_empty && !w_busy));
  assign w_count_ext = STAT_CNT_W'(w_count);

  nios2_system_link_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .i_push  (w_wr_data),
    .i_data  (writedata[7:0]),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Two-flop synchroniser for the asynchronous remote acknowledge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ack_m <= 1'b0;
      r_ack_s <= 1'b0;
    end else begin
      r_ack_m <= ack_in;
      r_ack_s <= r_ack_m;
    end
  end

  // Handshake sequencer: present byte, hold for setup, strobe, await ack rise/fall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      out_port   <= 8'h00;
      strobe_out <= 1'b0;
      r_last     <= 8'h00;
    end else if (w_flush) begin
      r_state    <= ST_IDLE;
      strobe_out <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_en && !w_empty && !r_tmo) begin
            out_port <= w_head;
            r_cnt    <= '0;
            r_state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (r_cnt == CNT_W'(SETUP_CYCLES - 1)) begin
            r_cnt      <= '0;
            strobe_out <= 1'b1;
            r_state    <= ST_STROBE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_STROBE: begin
          if (r_ack_s) begin
            r_cnt      <= '0;
            strobe_out <= 1'b0;
            r_state    <= ST_RELEASE;
          end else if (w_tmo_set) begin
            strobe_out <= 1'b0;
            r_state    <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (w_pop) begin
            r_last  <= out_port;
            r_state <= ST_IDLE;
          end else if (w_tmo_set) begin
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Control bits and sticky error flags; a new error wins over a same-cycle clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en     <= 1'b0;
      r_irq_en <= 1'b0;
      r_tmo    <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= writedata[CTRL_EN];
        r_irq_en <= writedata[CTRL_IRQ_EN];
      end
      if (w_tmo_set)        r_tmo <= 1'b1;
      else if (w_wr_errclr) r_tmo <= 1'b0;
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (w_wr_errclr) r_ovf <= 1'b0;
    end
  end

  // Zero-wait-state read mux
  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[7:0] = r_last;
      ADDR_STATUS: begin
        readdata[STAT_BUSY]  = w_busy;
        readdata[STAT_FULL]  = w_full;
        readdata[STAT_EMPTY] = w_empty;
        readdata[STAT_TMO]   = r_tmo;
        readdata[STAT_OVF]   = r_ovf;
        readdata[STAT_CNT_MSB:STAT_CNT_LSB] = w_count_ext;
      end
      ADDR_CTRL: begin
        readdata[CTRL_EN]     = r_en;
        readdata[CTRL_IRQ_EN] = r_irq_en;
      end
      default: readdata = '0;
    endcase
  end

endmodule

`default_nettype wire
